// File: rtl/uart_dbus_bridge.sv
// rtl/uart_dbus_bridge.sv - UART byte-frame to data-bus command bridge
module uart_dbus_bridge #(
    parameter int WL             = 32,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          tx_rdy,
    output logic          tx_vld,
    output logic [7:0]    tx_data,
    output logic          dbus_cmd_valid,
    input  logic          dbus_cmd_ready,
    output logic          dbus_cmd_payload_wr,
    output logic [WL-1:0] dbus_cmd_payload_address,
    output logic [WL-1:0] dbus_cmd_payload_data,
    output logic [1:0]    dbus_cmd_payload_size,
    input  logic          dbus_rsp_ready,
    input  logic          dbus_rsp_error,
    input  logic [WL-1:0] dbus_rsp_data,
    output logic          busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CMD  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_TX   = 3'd5;

    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_TOUT = 8'h54;

    logic [2:0]    state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [WL-1:0] addr_q, addr_d;
    logic [WL-1:0] data_q, data_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [23:0]   tx_shift_q, tx_shift_d;
    logic [1:0]    tx_left_q, tx_left_d;
    logic          tx_gap_q, tx_gap_d;
    logic [TW-1:0] timer_q, timer_d;

    logic tx_fire;
    logic timed_out;
    logic timed_state;

    // A byte goes out only when the UART is idle and the post-pulse gap cycle has passed
    assign tx_fire     = (state_q == S_TX) && tx_rdy && !tx_gap_q;
    assign timed_out   = (timer_q == TMAX);
    assign timed_state = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_WAIT);

    // Frame parsing, bus handshake and response sequencing
    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_shift_d = tx_shift_q;
        tx_left_d  = tx_left_q;
        tx_gap_d   = tx_gap_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        state_d = S_ADDR;
                        is_wr_d = (rx_data == OP_WR);
                        cnt_d   = 2'd0;
                    end else begin
                        state_d   = S_TX;
                        tx_data_d = RSP_BAD;
                        tx_left_d = 2'd0;
                        tx_gap_d  = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = is_wr_q ? S_DATA : S_CMD;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_CMD;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (dbus_cmd_ready) begin
                    if (is_wr_q) begin
                        state_d   = S_TX;
                        tx_data_d = RSP_OK;
                        tx_left_d = 2'd0;
                        tx_gap_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dbus_rsp_ready) begin
                    state_d  = S_TX;
                    tx_gap_d = 1'b1;
                    if (dbus_rsp_error) begin
                        tx_data_d = RSP_ERR;
                        tx_left_d = 2'd0;
                    end else begin
                        tx_data_d  = dbus_rsp_data[7:0];
                        tx_shift_d = dbus_rsp_data[31:8];
                        tx_left_d  = 2'd3;
                    end
                end else if (timed_out) begin
                    state_d   = S_TX;
                    tx_data_d = RSP_TOUT;
                    tx_left_d = 2'd0;
                    tx_gap_d  = 1'b1;
                end
            end
            S_TX: begin
                tx_gap_d = tx_fire;
                if (tx_fire) begin
                    if (tx_left_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_data_d  = tx_shift_q[7:0];
                        tx_shift_d = {8'h00, tx_shift_q[23:8]};
                        tx_left_d  = tx_left_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_valid || (state_d != state_q) || !timed_state) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_shift_q <= 24'h0;
            tx_left_q  <= 2'd0;
            tx_gap_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_shift_q <= tx_shift_d;
            tx_left_q  <= tx_left_d;
            tx_gap_q   <= tx_gap_d;
            timer_q    <= timer_d;
        end
    end

    // Strobes are gated by reset so an abort takes effect in the same cycle
    assign tx_vld                   = tx_fire && !reset;
    assign tx_data                  = tx_data_q;
    assign dbus_cmd_valid           = (state_q == S_CMD) && !reset;
    assign dbus_cmd_payload_wr      = is_wr_q;
    assign dbus_cmd_payload_address = addr_q;
    assign dbus_cmd_payload_data    = data_q;
    assign dbus_cmd_payload_size    = 2'b10;
    assign busy                     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_dbus_bridge.sv
// tb/tb_uart_dbus_bridge.sv - scoreboard bench for uart_dbus_bridge
module tb_uart_dbus_bridge;

    localparam int WL = 32;
    localparam int TO = 40;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_rdy;
    logic          tx_vld;
    logic [7:0]    tx_data;
    logic          dbus_cmd_valid;
    logic          dbus_cmd_ready;
    logic          dbus_cmd_payload_wr;
    logic [WL-1:0] dbus_cmd_payload_address;
    logic [WL-1:0] dbus_cmd_payload_data;
    logic [1:0]    dbus_cmd_payload_size;
    logic          dbus_rsp_ready;
    logic          dbus_rsp_error;
    logic [WL-1:0] dbus_rsp_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tx[$];
    cmd_t       exp_cmd[$];

    int   tx_seen = 0;
    int   last_seen = 0;
    int   hold = 0;
    bit   uart_slow = 0;
    bit   prev_tx_vld = 0;
    bit   prev_pending = 0;
    cmd_t prev_payload;

    uart_dbus_bridge #(.WL(WL), .TIMEOUT_CYCLES(TO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .rx_valid                 (rx_valid),
        .rx_data                  (rx_data),
        .tx_rdy                   (tx_rdy),
        .tx_vld                   (tx_vld),
        .tx_data                  (tx_data),
        .dbus_cmd_valid           (dbus_cmd_valid),
        .dbus_cmd_ready           (dbus_cmd_ready),
        .dbus_cmd_payload_wr      (dbus_cmd_payload_wr),
        .dbus_cmd_payload_address (dbus_cmd_payload_address),
        .dbus_cmd_payload_data    (dbus_cmd_payload_data),
        .dbus_cmd_payload_size    (dbus_cmd_payload_size),
        .dbus_rsp_ready           (dbus_rsp_ready),
        .dbus_rsp_error           (dbus_rsp_error),
        .dbus_rsp_data            (dbus_rsp_data),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic [7:0] e;
        cmd_t       c;
        cmd_t       now_payload;
        forever begin
            @(negedge clk);
            now_payload = {dbus_cmd_payload_wr, dbus_cmd_payload_address, dbus_cmd_payload_data};
            if (tx_vld === 1'b1) begin
                tx_seen++;
                checks++;
                if (tx_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_rdy_low: tx_vld with tx_rdy=%b, required 1", tx_rdy);
                end
                checks++;
                if (prev_tx_vld) begin
                    errors++;
                    $display("FAIL tx_gap: tx_vld in consecutive cycles, required a gap cycle");
                end
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: byte %h sent, none expected", tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, e);
                    end
                end
            end
            prev_tx_vld = (tx_vld === 1'b1);

            if (dbus_cmd_valid === 1'b1 && prev_pending) begin
                checks++;
                if (now_payload !== prev_payload) begin
                    errors++;
                    $display("FAIL cmd_stable: payload %h changed from %h while waiting", now_payload, prev_payload);
                end
            end
            if (dbus_cmd_valid === 1'b1 && dbus_cmd_ready === 1'b1) begin
                checks++;
                if (exp_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: command %h accepted, none expected", now_payload);
                end else begin
                    c = exp_cmd.pop_front();
                    if (dbus_cmd_payload_wr !== c.wr || dbus_cmd_payload_address !== c.addr ||
                        (c.wr && dbus_cmd_payload_data !== c.data) || dbus_cmd_payload_size !== 2'b10) begin
                        errors++;
                        $display("FAIL cmd_payload: got wr=%b addr=%h data=%h size=%b, required wr=%b addr=%h data=%h size=10",
                                 dbus_cmd_payload_wr, dbus_cmd_payload_address, dbus_cmd_payload_data,
                                 dbus_cmd_payload_size, c.wr, c.addr, c.data);
                    end
                end
            end
            prev_pending = (dbus_cmd_valid === 1'b1) && (dbus_cmd_ready !== 1'b1);
            prev_payload = now_payload;
        end
    endtask

    task automatic uart_model();
        forever begin
            @(posedge clk);
            #2;
            if (tx_seen != last_seen) begin
                last_seen = tx_seen;
                if (uart_slow) begin
                    tx_rdy = 1'b0;
                    hold   = 3;
                end
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) tx_rdy = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic do_cmd(input int nwait);
        int n = 0;
        while (dbus_cmd_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (dbus_cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL cmd_wait: dbus_cmd_valid=%b after %0d cycles, required 1", dbus_cmd_valid, n);
        end
        repeat (nwait) begin
            @(posedge clk);
            #1;
        end
        dbus_cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        dbus_cmd_ready = 1'b0;
    endtask

    task automatic give_rsp(input logic [31:0] d, input logic err, input int delay);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        dbus_rsp_ready = 1'b1;
        dbus_rsp_error = err;
        dbus_rsp_data  = d;
        @(posedge clk);
        #1;
        dbus_rsp_ready = 1'b0;
        dbus_rsp_error = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_vld, dbus_cmd_valid, dbus_cmd_payload_wr, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: vld/cmd/wr/busy=%b, required 0000",
                     {tx_vld, dbus_cmd_valid, dbus_cmd_payload_wr, busy});
        end
        checks++;
        if (tx_data !== 8'h00 || dbus_cmd_payload_address !== '0 || dbus_cmd_payload_data !== '0) begin
            errors++;
            $display("FAIL reset_data: tx=%h addr=%h data=%h, required zeros",
                     tx_data, dbus_cmd_payload_address, dbus_cmd_payload_data);
        end
        checks++;
        if (dbus_cmd_payload_size !== 2'b10) begin
            errors++;
            $display("FAIL reset_size: got %b, required 10", dbus_cmd_payload_size);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write(input logic [31:0] a, input logic [31:0] d);
        exp_cmd.push_back({1'b1, a, d});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_word(a);
        send_word(d);
        checks++;
        if (dbus_cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL cmd_latency: dbus_cmd_valid=%b after final byte, required 1", dbus_cmd_valid);
        end
        do_cmd(1);
        wait_idle(50);
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] d, input int nwait);
        uart_slow = 1'b1;
        exp_cmd.push_back({1'b0, a, 32'h0});
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
        send_byte(8'h52);
        send_word(a);
        do_cmd(nwait);
        give_rsp(d, 1'b0, 2);
        send_byte(8'h41);
        wait_idle(100);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_tx.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done: %0d bytes outstanding busy=%b, required 0 and 0", exp_tx.size(), busy);
        end
        uart_slow = 1'b0;
    endtask

    task automatic test_read_error();
        exp_cmd.push_back({1'b0, 32'h0000_2000, 32'h0});
        exp_tx.push_back(8'h45);
        send_byte(8'h52);
        send_word(32'h0000_2000);
        do_cmd(0);
        give_rsp(32'hFFFF_FFFF, 1'b1, 3);
        wait_idle(50);
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL rsp_error: busy=%b outstanding=%0d, required 0 and 0", busy, exp_tx.size());
        end
    endtask

    task automatic test_bad_opcode_timeout();
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle(50);
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (TO - 2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_timeout_early: busy=%b before timeout, required 1", busy);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL frame_timeout: busy=%b outstanding=%0d, required 0 and 0", busy, exp_tx.size());
        end
    endtask

    task automatic test_rsp_timeout();
        exp_cmd.push_back({1'b0, 32'h0000_0040, 32'h0});
        exp_tx.push_back(8'h54);
        send_byte(8'h52);
        send_word(32'h0000_0040);
        do_cmd(0);
        repeat (TO - 5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || exp_tx.size() != 1) begin
            errors++;
            $display("FAIL rsp_timeout_early: busy=%b outstanding=%0d, required 1 and 1", busy, exp_tx.size());
        end
        wait_idle(30);
        checks++;
        if (exp_tx.size() != 0) begin
            errors++;
            $display("FAIL rsp_timeout: outstanding=%0d, required 0", exp_tx.size());
        end
    endtask

    task automatic test_reset_in_cmd();
        send_byte(8'h52);
        send_word(32'h0000_0300);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (dbus_cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_same: dbus_cmd_valid=%b during reset, required 0", dbus_cmd_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dbus_cmd_valid !== 1'b0 || tx_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: cmd=%b tx=%b busy=%b, required 000", dbus_cmd_valid, tx_vld, busy);
        end
        reset = 1'b0;
        test_write(32'h0000_0400, 32'hCAFE_F00D);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        give_rsp(32'h1111_1111, 1'b0, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_rsp: busy=%b after rsp in idle, required 0", busy);
        end
        for (int k = 0; k < 3; k++) begin
            a = $urandom;
            d = $urandom;
            test_write(a, d);
            test_read(a, d, k);
        end
    endtask

    initial begin
        reset          = 1'b1;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        tx_rdy         = 1'b1;
        dbus_cmd_ready = 1'b0;
        dbus_rsp_ready = 1'b0;
        dbus_rsp_error = 1'b0;
        dbus_rsp_data  = '0;
        fork
            monitor();
            uart_model();
        join_none

        test_reset();
        test_write(32'h8000_0010, 32'hDEAD_BEEF);
        test_read(32'h0000_0100, 32'h1234_5678, 3);
        test_read_error();
        test_bad_opcode_timeout();
        test_rsp_timeout();
        test_reset_in_cmd();
        test_back_to_back();

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_tx.size() != 0 || exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: tx=%0d cmd=%0d outstanding, required 0 and 0",
                     exp_tx.size(), exp_cmd.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
